// File: rtl/display_scan.sv
// Purpose: time-multiplexed scan of an 8-digit 7-segment tube with dead-time blanking,
//          tear-free frame swap at the frame boundary and optional leading-zero suppression.
// Latency: outputs registered, one cycle behind cnt/idx; no backpressure (free-running scan).
module display_scan #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int NUM_DIGITS  = 8,
  parameter int DEAD_CYCLES = 100,
  parameter int BLANK_CODE  = 36
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      lz_en,
  input  logic                      load,
  input  logic [6*NUM_DIGITS-1:0]   chars_in,
  output logic [5:0]                char_code,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_done
);

  // Cycles spent on each digit slot.
  localparam int T     = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (T > 1) ? $clog2(T) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [5:0]       BLANK    = 6'(BLANK_CODE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0][5:0] BLANK_FRAME = {NUM_DIGITS{BLANK}};

  // Scan position.
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  // Double-buffered frame: active is what is displayed, pending waits for the boundary.
  logic [NUM_DIGITS-1:0][5:0] active;
  logic [NUM_DIGITS-1:0][5:0] pending;
  logic                       pend;

  logic                  slot_end;
  logic                  frame_end;
  logic                  show;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [5:0]            eff_code;
  logic [NUM_DIGITS-1:0] onehot;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  // Dead phase at the start of every slot stops the previous digit ghosting into the next.
  assign show      = enable && (cnt >= CNT_DEAD);

  // Slot counter and digit index; keep running even while the display is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame buffering: loads land in pending; active only changes on the frame boundary,
  // where a same-cycle load wins over an older pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= BLANK_FRAME;
      pending <= '0;
      pend    <= 1'b0;
    end else begin
      if (load) begin
        pending <= chars_in;
      end
      if (frame_end) begin
        if (load) begin
          active <= chars_in;
        end else if (pend) begin
          active <= pending;
        end
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  // Leading-zero mask: a digit is suppressible when it and every digit above it is zero;
  // digit 0 always shows so an all-zero frame still reads "0".
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run & (active[k] == 6'd0);
      lz_mask[k] = zero_run & (k != 0);
    end
  end

  // Effective code of the current digit and its one-hot select.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    eff_code    = (lz_en && lz_mask[idx]) ? BLANK : active[idx];
  end

  // Registered outputs; codes above BLANK pass through untouched for the decoder to blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code  <= BLANK;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end && (load || pend);
      if (show) begin
        digit_en  <= onehot;
        char_code <= eff_code;
      end else begin
        digit_en  <= '0;
        char_code <= BLANK;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Purpose: randomized + directed bench for display_scan against a cycle-count based model.
// Latency: model predicts outputs one cycle after the scan position they describe.
// Backpressure: none; stimulus is free-running.
module tb_display_scan;
  localparam int ND    = 8;
  localparam int T     = 8;
  localparam int DEAD  = 2;
  localparam int BLANK = 36;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            lz_en = 1'b0;
  logic            load = 1'b0;
  logic [6*ND-1:0] chars_in = '0;
  logic [5:0]      char_code;
  logic [ND-1:0]   digit_en;
  logic            frame_done;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;

  display_scan #(
    .CLK_HZ(80), .SCAN_HZ(10), .NUM_DIGITS(ND), .DEAD_CYCLES(DEAD), .BLANK_CODE(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lz_en(lz_en), .load(load),
    .chars_in(chars_in), .char_code(char_code), .digit_en(digit_en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model state: scan position derived from cycles since reset release.
  int m_t;
  int m_act[ND];
  int m_pen[ND];
  bit m_pend;
  int e_en;
  int e_code;
  int e_fd;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_eff(input int i);
    bit z;
    z = 1'b1;
    for (int j = i; j < ND; j++) if (m_act[j] != 0) z = 1'b0;
    if (lz_en && i != 0 && z) return BLANK;
    return m_act[i];
  endfunction

  // Reference model stepped on every clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0;
      for (int j = 0; j < ND; j++) begin m_act[j] = BLANK; m_pen[j] = 0; end
      m_pend = 1'b0;
      e_en = 0; e_code = BLANK; e_fd = 0;
    end else begin
      int c;
      int i;
      c = m_t % T;
      i = (m_t / T) % ND;
      if (enable && c >= DEAD) begin
        e_en = 1 << i;
        e_code = m_eff(i);
      end else begin
        e_en = 0;
        e_code = BLANK;
      end
      e_fd = 0;
      if (c == T - 1 && i == ND - 1) begin
        if (load) begin
          for (int j = 0; j < ND; j++) m_act[j] = int'(chars_in[6*j +: 6]);
          e_fd = 1;
        end else if (m_pend) begin
          for (int j = 0; j < ND; j++) m_act[j] = m_pen[j];
          e_fd = 1;
        end
        m_pend = 1'b0;
      end else if (load) begin
        for (int j = 0; j < ND; j++) m_pen[j] = int'(chars_in[6*j +: 6]);
        m_pend = 1'b1;
      end
      m_t++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("digit_en", int'(digit_en), e_en);
    chk("char_code", int'(char_code), e_code);
    chk("frame_done", int'(frame_done), e_fd);
    if (frame_done) fd_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return when the next edge will process scan position (c, i).
  task automatic wait_slot(input int c, input int i);
    int n;
    n = 0;
    while (!((m_t % T) == c && ((m_t / T) % ND) == i)) begin
      step();
      n++;
      if (n > 2000) begin
        chk("wait_slot_timeout", 0, 1);
        return;
      end
    end
  endtask

  // Literal expectation for the output produced by scan position (c, i).
  task automatic show_chk(input string name, input int c, input int i, input int en, input int code);
    wait_slot(c, i);
    step();
    chk({name, "_en"}, int'(digit_en), en);
    chk({name, "_code"}, int'(char_code), code);
  endtask

  task automatic pulse_load(input logic [6*ND-1:0] v);
    chars_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  logic [6*ND-1:0] fa;
  logic [6*ND-1:0] fb;

  initial begin
    for (int k = 0; k < ND; k++) begin
      fa[6*k +: 6] = 6'(10 + k);
      fb[6*k +: 6] = 6'(37 + k);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", int'(digit_en), 0);
    chk("reset_code", int'(char_code), BLANK);
    chk("reset_fd", int'(frame_done), 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // Blank frame after reset: two dead cycles then digit 0.
    step(); chk("s1_dead0", int'(digit_en), 0);
    step(); chk("s1_dead1", int'(digit_en), 0);
    step(); chk("s1_show0_en", int'(digit_en), 1);
    chk("s1_show0_code", int'(char_code), BLANK);
    show_chk("s1_d5", 3, 5, 32, BLANK);

    // Load mid-frame is held until the boundary.
    wait_slot(0, 3);
    fd_count = 0;
    pulse_load({6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
    show_chk("s2_same_frame", 4, 5, 32, BLANK);
    chk("s2_no_fd_yet", fd_count, 0);
    show_chk("s2_next_d0", 2, 0, 1, 1);
    chk("s2_fd_once", fd_count, 1);
    show_chk("s2_next_d5", 4, 5, 32, 6);

    // Leading-zero suppression.
    lz_en = 1'b1;
    wait_slot(0, 3);
    pulse_load({6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3});
    show_chk("s3_d0", 3, 0, 1, 3);
    show_chk("s3_d2", 3, 2, 4, 1);
    show_chk("s3_d3", 3, 3, 8, BLANK);
    show_chk("s3_d7", 3, 7, 128, BLANK);
    wait_slot(0, 3);
    pulse_load('0);
    show_chk("s3_zero_d0", 3, 0, 1, 0);
    show_chk("s3_zero_d1", 3, 1, 2, BLANK);
    lz_en = 1'b0;
    show_chk("s3_lzoff_d1", 3, 1, 2, 0);

    // Boundary load overrides an older pending frame.
    wait_slot(0, 2);
    pulse_load(fa);
    wait_slot(7, 7);
    fd_count = 0;
    pulse_load(fb);
    show_chk("s4_d1", 3, 1, 2, 38);
    chk("s4_fd_once", fd_count, 1);
    show_chk("s4_d1_again", 3, 1, 2, 38);
    chk("s4_no_second_fd", fd_count, 1);

    // Disable for three slots; scan resumes where the counter is.
    wait_slot(0, 2);
    enable = 1'b0;
    show_chk("s5_off_d2", 4, 2, 0, BLANK);
    show_chk("s5_off_d4", 4, 4, 0, BLANK);
    wait_slot(0, 5);
    enable = 1'b1;
    show_chk("s5_resume_d5", 4, 5, 32, 42);

    // Reset mid-slot with a pending load outstanding.
    wait_slot(0, 4);
    pulse_load(fa);
    wait_slot(5, 4);
    rst_n = 1'b0;
    #1;
    chk("s6_async_en", int'(digit_en), 0);
    chk("s6_async_code", int'(char_code), BLANK);
    step();
    rst_n = 1'b1;
    fd_count = 0;
    step(); chk("s6_dead0", int'(digit_en), 0);
    step(); chk("s6_dead1", int'(digit_en), 0);
    step(); chk("s6_first_en", int'(digit_en), 1);
    chk("s6_first_code", int'(char_code), BLANK);
    show_chk("s6_next_frame_d3", 4, 3, 8, BLANK);
    chk("s6_pending_lost", fd_count, 0);

    // Random traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        for (int k = 0; k < ND; k++)
          chars_in[6*k +: 6] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      step();
    end
    load = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
